// File: rtl/alu_operand_stack.sv
// alu_operand_stack
//   Data stack for the brus16 execute stage. It supplies both ALU operands
//   (a = second from top, b = top) combinationally and takes the ALU result
//   back on BINOP, which pops two entries and pushes one in a single cycle.
//   It also runs the pure stack commands and raises sticky overflow and
//   underflow flags.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   cmd         000 NOP, 001 PUSH, 010 POP, 011 BINOP,
//               100 DUP, 101 SWAP, 110 OVER, 111 DROP2
//   push_data   value written by PUSH
//   alu_result  combinational ALU output, written by BINOP
//   alu_a       entry at count-2, or zero when count < 2
//   alu_b       entry at count-1 (top), or zero when empty
//   count       number of valid entries
//   empty/full  count == 0 / count == DEPTH
//   overflow    sticky: a command would have exceeded DEPTH
//   underflow   sticky: a command needed more entries than were present
module alu_operand_stack #(
  parameter int DEPTH = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cmd,
  input  logic [15:0]   push_data,
  input  logic [15:0]   alu_result,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'b000,
    CMD_PUSH  = 3'b001,
    CMD_POP   = 3'b010,
    CMD_BINOP = 3'b011,
    CMD_DUP   = 3'b100,
    CMD_SWAP  = 3'b101,
    CMD_OVER  = 3'b110,
    CMD_DROP2 = 3'b111
  } cmd_e;

  cmd_e op;
  assign op = cmd_e'(cmd);

  logic [15:0] mem [DEPTH];

  logic [CW-1:0] cnt_m1;
  logic [CW-1:0] cnt_m2;
  logic [AW-1:0] idx0;   // first free slot
  logic [AW-1:0] idx1;   // top
  logic [AW-1:0] idx2;   // second from top

  assign cnt_m1 = count - CW'(1);
  assign cnt_m2 = count - CW'(2);
  assign idx0   = count[AW-1:0];
  assign idx1   = cnt_m1[AW-1:0];
  assign idx2   = cnt_m2[AW-1:0];

  logic [1:0]    need;
  logic          grows;
  logic [CW-1:0] next_count;
  logic          under_hit;
  logic          over_hit;
  logic          exec;

  always_comb begin
    need       = 2'd0;
    grows      = 1'b0;
    next_count = count;
    case (op)
      CMD_PUSH:  begin grows = 1'b1; next_count = count + CW'(1); end
      CMD_POP:   begin need = 2'd1;  next_count = cnt_m1; end
      CMD_BINOP: begin need = 2'd2;  next_count = cnt_m1; end
      CMD_DUP:   begin need = 2'd1;  grows = 1'b1; next_count = count + CW'(1); end
      CMD_SWAP:  begin need = 2'd2; end
      CMD_OVER:  begin need = 2'd2;  grows = 1'b1; next_count = count + CW'(1); end
      CMD_DROP2: begin need = 2'd2;  next_count = cnt_m2; end
      default:   begin end
    endcase
    // Underflow takes priority, so at most one flag is raised per cycle.
    under_hit = (count < CW'(need));
    over_hit  = !under_hit && grows && (count == CW'(DEPTH));
    exec      = !under_hit && !over_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (exec)      count     <= next_count;
      if (under_hit) underflow <= 1'b1;
      if (over_hit)  overflow  <= 1'b1;
    end
  end

  // Storage is deliberately not reset; slots at or above count are masked
  // off the outputs, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (!reset && exec) begin
      case (op)
        CMD_PUSH:  mem[idx0] <= push_data;
        CMD_BINOP: mem[idx2] <= alu_result;
        CMD_DUP:   mem[idx0] <= mem[idx1];
        CMD_SWAP: begin
          mem[idx1] <= mem[idx2];
          mem[idx2] <= mem[idx1];
        end
        CMD_OVER:  mem[idx0] <= mem[idx2];
        default:   begin end
      endcase
    end
  end

  assign alu_a = (count >= CW'(2)) ? mem[idx2] : '0;
  assign alu_b = (count != '0)     ? mem[idx1] : '0;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: doc/alu_operand_stack.md
Name: alu_operand_stack

Overview:
- Data stack that sources both ALU operands and sinks the ALU result for the brus16 stack-machine execute stage.
- Exposes the second-from-top entry as operand a and the top entry as operand b, combinationally.
- On a BINOP command, it pops both operands and pushes the ALU result in one cycle.
- Also executes the pure stack commands (push, pop, dup, swap, over, drop2), with sticky overflow/underflow detection.

Parameters:
- DEPTH, 32, number of 16-bit entries; must be at least 2.
- CW, $clog2(DEPTH+1), width of the count output; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd  input  3  stack command: 000 NOP, 001 PUSH, 010 POP, 011 BINOP, 100 DUP, 101 SWAP, 110 OVER, 111 DROP2.
- push_data  input  16  value written by PUSH.
- alu_result  input  16  combinational ALU output; consumed by BINOP.
- alu_a  output  16  entry at count-2; 16'h0000 when count<2.
- alu_b  output  16  entry at count-1 (top); 16'h0000 when count==0.
- count  output  CW  current number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set by any command that would exceed DEPTH.
- underflow  output  1  sticky; set by any command needing more entries than present.

Behaviour:
- Reset (synchronous, active-high) sets count=0, overflow=0, underflow=0, empty=1, full=0, alu_a=0, alu_b=0.
- Storage contents are not reset; entries at or above count are never visible on the outputs.
- alu_a, alu_b, empty and full are combinational from the current state, with zero-cycle latency after the clock edge.
- Each command completes in one cycle; effects are visible on the outputs after the edge.
- Entry requirement (need) and net count change (delta) per command:
  - NOP: need 0, delta 0.
  - PUSH: need 0, delta +1; top=push_data.
  - POP: need 1, delta -1.
  - BINOP: need 2, delta -1; the new top (old position count-2) takes alu_result sampled that cycle.
  - DUP: need 1, delta +1; new top = old top.
  - SWAP: need 2, delta 0; the top two entries exchange.
  - OVER: need 2, delta +1; new top = old entry at count-2.
  - DROP2: need 2, delta -2.
- Illegal command, checked in priority order:
  - If count<need: no state change; underflow<=1.
  - Else if count+delta>DEPTH: no state change; overflow<=1.
  - Only one flag can be set per cycle.
- Sticky flags clear only on reset; commands keep executing normally while a flag is set.
- BINOP at count==DEPTH is legal (delta -1). PUSH, DUP and OVER at count==DEPTH raise overflow.
- reset asserted in the same cycle as any cmd: reset wins, and the command is discarded.
- No state machine beyond the count/flags; there is no busy signal, and a new command is accepted every cycle.
- Arithmetic is 16-bit, with no width extension; alu_result is written verbatim.

Test Plan:
- Reset, then PUSH 16'h0005, then PUSH 16'h0003. Required after the second push: count=2, alu_a=5, alu_b=3, empty=0.
- From count=2 (a=5, b=3), drive alu_result=16'h0008 with BINOP. Required: count=1, alu_b=8, alu_a=0, no flags.
- From reset, POP. Required: count stays 0, underflow=1, overflow=0. Then PUSH 16'h0001: count=1, and underflow remains 1.
- Push DEPTH distinct values 1..32. Required: full=1.
  - DUP: overflow=1 and count=32 unchanged.
  - BINOP with alu_result=16'hFFFF: count=31, alu_b=FFFF, alu_a=30.
- Stack [7,9] (top 9):
  - SWAP gives a=9, b=7.
  - OVER then gives count=3, b=9, a=7.
  - DROP2 then gives count=1, b=9.
- Assert reset with cmd=PUSH at count=4. Required next cycle: count=0, flags=0, alu_a=alu_b=0.
